// File: rtl/onehot_key_if.sv
// Key-code handshake bundle between onehot_key_encoder (master) and its consumer (slave).
interface onehot_key_if #(
  parameter int CW = 4
);
  logic [CW-1:0] code_o;
  logic          valid_o;
  logic          ready_i;
  logic          multi_o;
  logic          busy_o;

  modport master (output code_o, output valid_o, output multi_o, output busy_o, input ready_i);
  modport slave  (input code_o, input valid_o, input multi_o, input busy_o, output ready_i);
endinterface

// File: rtl/onehot_key_encoder.sv
// Synchronised, debounced one-hot key encoder with valid/ready code output and release re-arm.
// Optional macro ONEHOT_KEY_PRIORITY_EN: accept the lowest set bit of a multi-hot vector instead of rejecting it.
module onehot_key_encoder #(
  parameter int N          = 9,
  parameter int CW         = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] x_in,
  onehot_key_if.master kif
);

  if (((1 << CW) - 1) < N) begin : g_cw_check
    $fatal(1, "onehot_key_encoder: CW too narrow for N key codes");
  end
  if (DEB_CYCLES < 1) begin : g_deb_check
    $fatal(1, "onehot_key_encoder: DEB_CYCLES must be >= 1");
  end

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N-1:0]     ONE      = N'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
    return v & (~v + ONE);
  endfunction

  function automatic logic [CW-1:0] key_code(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) c = CW'(i + 1);
    end
    return c;
  endfunction

  logic [N-1:0]     x_p0, x_s;
  logic [1:0]       state, state_nxt;
  logic [N-1:0]     cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CW-1:0]    code_q, code_nxt;
  logic             valid_q, valid_nxt;
  logic             multi_q, multi_nxt;
  logic             busy_q;
  logic             key_match;

  // Stage p0/p1: two-flop synchroniser for the asynchronous key lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p0 <= '0;
      x_s  <= '0;
    end else begin
      x_p0 <= x_in;
      x_s  <= x_p0;
    end
  end

`ifdef ONEHOT_KEY_PRIORITY_EN
  assign key_match = (x_s & cand) != '0;
`else
  assign key_match = (x_s == cand);
`endif

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    code_nxt  = code_q;
    valid_nxt = valid_q;
    multi_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (x_s != '0) begin
`ifdef ONEHOT_KEY_PRIORITY_EN
          cand_nxt  = lowest_bit(x_s);
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
`else
          if (is_onehot(x_s)) begin
            cand_nxt  = x_s;
            cnt_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            multi_nxt = 1'b1;
            state_nxt = RELEASE;
          end
`endif
        end
      end
      DEBOUNCE: begin
        if (!key_match) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          code_nxt  = key_code(cand);
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HOLD: begin
        // Key-line activity is ignored until the consumer takes the code
        if (valid_q && kif.ready_i) begin
          code_nxt  = '0;
          valid_nxt = 1'b0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (x_s == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p2: state, candidate, debounce count and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cand    <= '0;
      cnt     <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cand    <= cand_nxt;
      cnt     <= cnt_nxt;
      code_q  <= code_nxt;
      valid_q <= valid_nxt;
      multi_q <= multi_nxt;
      busy_q  <= (state_nxt != IDLE);
    end
  end

  assign kif.code_o  = code_q;
  assign kif.valid_o = valid_q;
  assign kif.multi_o = multi_q;
  assign kif.busy_o  = busy_q;

endmodule

// File: tb/tb_onehot_key_encoder.sv
// Scoreboard bench for onehot_key_encoder: default N=9 instance plus an N=15 instance for the top key code.
module tb_onehot_key_encoder;

  localparam int N  = 9;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  x_in;
  logic [14:0]   x15;

  always #5 clk = ~clk;

  onehot_key_if #(.CW(CW)) kif ();
  onehot_key_if #(.CW(4))  kif15 ();

  onehot_key_encoder #(.N(N), .CW(CW), .DEB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x_in  (x_in),
    .kif   (kif)
  );

  onehot_key_encoder #(.N(15), .CW(4), .DEB_CYCLES(4)) dut15 (
    .clk   (clk),
    .rst_n (rst_n),
    .x_in  (x15),
    .kif   (kif15)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int multi_cnt = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; waits return at the same point.
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Values seen at the falling edge are what the next rising edge consumes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kif.multi_o) multi_cnt++;
      if (kif.valid_o && kif.ready_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) check_eq("unexpected_valid", 32'(kif.valid_o), 32'd0);
        else check_eq("code", 32'(kif.code_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int h0;
    int m0;
    rst_n = 1'b0;
    x_in = '0;
    x15 = '0;
    kif.ready_i = 1'b0;
    kif15.ready_i = 1'b0;
    tick(3);
    check_eq("rst_code", 32'(kif.code_o), 32'd0);
    check_eq("rst_valid", 32'(kif.valid_o), 32'd0);
    check_eq("rst_busy", 32'(kif.busy_o), 32'd0);
    check_eq("rst_multi", 32'(kif.multi_o), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Clean press of key 3, consumer always ready
    kif.ready_i = 1'b1;
    x_in = 9'b000000100;
    exp_q.push_back(4'd3);
    h0 = hs_cnt;
    tick(6);
    check_eq("lat_early_valid", 32'(kif.valid_o), 32'd0);
    check_eq("busy_debounce", 32'(kif.busy_o), 32'd1);
    tick(1);
    check_eq("lat_valid", 32'(kif.valid_o), 32'd1);
    check_eq("lat_code", 32'(kif.code_o), 32'd3);
    tick(1);
    check_eq("one_cycle_valid", 32'(kif.valid_o), 32'd0);
    check_eq("code_cleared", 32'(kif.code_o), 32'd0);
    tick(20);
    check_eq("no_repeat", 32'(hs_cnt - h0), 32'd1);
    check_eq("release_busy", 32'(kif.busy_o), 32'd1);
    x_in = '0;
    tick(4);
    check_eq("rearm_idle", 32'(kif.busy_o), 32'd0);

    // Bouncing key 5, then stable
    h0 = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      x_in = (i % 2 == 0) ? 9'b000010000 : 9'b000000000;
      tick(2);
    end
    check_eq("bounce_quiet", 32'(hs_cnt - h0), 32'd0);
    x_in = 9'b000010000;
    exp_q.push_back(4'd5);
    tick(12);
    check_eq("bounce_once", 32'(hs_cnt - h0), 32'd1);
    x_in = '0;
    tick(5);

    // Backpressure on key 9 with key-line activity during HOLD
    kif.ready_i = 1'b0;
    x_in = 9'b100000000;
    exp_q.push_back(4'd9);
    for (int i = 0; i < 20 && !kif.valid_o; i++) tick(1);
    check_eq("bp_valid_seen", 32'(kif.valid_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid_held", 32'(kif.valid_o), 32'd1);
      check_eq("bp_code_held", 32'(kif.code_o), 32'd9);
      if (i == 3) x_in = 9'b000000001;
      if (i == 6) x_in = '0;
      tick(1);
    end
    kif.ready_i = 1'b1;
    tick(1);
    check_eq("bp_accept_valid", 32'(kif.valid_o), 32'd0);
    check_eq("bp_accept_code", 32'(kif.code_o), 32'd0);
    tick(5);
    check_eq("bp_back_idle", 32'(kif.busy_o), 32'd0);

    // Multi-hot vector (keys 2 and 6)
    h0 = hs_cnt;
    m0 = multi_cnt;
    x_in = 9'b000100010;
`ifdef ONEHOT_KEY_PRIORITY_EN
    exp_q.push_back(4'd2);
`endif
    tick(15);
`ifdef ONEHOT_KEY_PRIORITY_EN
    check_eq("prio_multi_pulses", 32'(multi_cnt - m0), 32'd0);
    check_eq("prio_codes", 32'(hs_cnt - h0), 32'd1);
`else
    check_eq("multi_pulses", 32'(multi_cnt - m0), 32'd1);
    check_eq("multi_no_code", 32'(hs_cnt - h0), 32'd0);
    check_eq("multi_busy", 32'(kif.busy_o), 32'd1);
`endif
    x_in = '0;
    tick(5);

    // Top key on the N=15 instance
    x15 = 15'h4000;
    for (int i = 0; i < 20 && !kif15.valid_o; i++) tick(1);
    check_eq("top_valid", 32'(kif15.valid_o), 32'd1);
    check_eq("top_code", 32'(kif15.code_o), 32'd15);
    kif15.ready_i = 1'b1;
    tick(1);
    check_eq("top_accept", 32'(kif15.valid_o), 32'd0);
    x15 = '0;
    tick(5);

    // Asynchronous reset while code 5 is pending
    kif.ready_i = 1'b0;
    x_in = 9'b000010000;
    for (int i = 0; i < 20 && !kif.valid_o; i++) tick(1);
    check_eq("hold_code5", 32'(kif.code_o), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_code", 32'(kif.code_o), 32'd0);
    check_eq("async_rst_valid", 32'(kif.valid_o), 32'd0);
    check_eq("async_rst_busy", 32'(kif.busy_o), 32'd0);
    x_in = '0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_eq("post_rst_valid", 32'(kif.valid_o), 32'd0);

    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_key_encoder.md
Name: onehot_key_encoder

Overview:
- Registered, parametrised successor to the one-hot keypad encoder.
- Synchronises an N-line one-hot key vector and debounces it for DEB_CYCLES clocks.
- Emits the 1-based key index as a binary code through a valid/ready handshake, then waits for all keys released before arming again.
- Sits between raw keypad/switch inputs and the control FSM that consumes key codes.

Parameters:
- N, 9, number of one-hot input lines.
- CW, 4, code width; must satisfy 2^CW-1 >= N (elaboration-time check, fatal if violated).
- DEB_CYCLES, 4, consecutive matching synchronised samples required before a key is accepted; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- x_in  input  N  raw key lines, asynchronous to clk; bit i set = key i+1 pressed.
- code_o  output  CW  accepted key code (i+1 for bit i); 0 when no code pending.
- valid_o  output  1  code_o holds an unconsumed code.
- ready_i  input  1  consumer accepts code when valid_o && ready_i at a rising edge.
- multi_o  output  1  one-cycle pulse: multi-hot vector detected (reject path).
- busy_o  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): synchroniser flops, candidate register and counter = 0; code_o=0, valid_o=0, multi_o=0, busy_o=0; state=IDLE. Reset mid-handshake discards the pending code, with no recovery.
- Synchroniser: two-flop chain on x_in, giving x_s. All decisions use x_s only.
- IDLE:
  - x_s == 0: stay.
  - x_s exactly one-hot: capture cand=x_s, cnt=0 -> DEBOUNCE.
  - x_s multi-hot: multi_o=1 for one cycle -> RELEASE.
- DEBOUNCE:
  - x_s != cand: -> IDLE, no output, cnt=0.
  - x_s == cand and cnt < DEB_CYCLES-1: cnt++.
  - x_s == cand and cnt == DEB_CYCLES-1: code_o=index(cand)+1, valid_o=1 -> HOLD.
- HOLD:
  - code_o and valid_o stay stable until the handshake; x_s changes are ignored.
  - valid_o && ready_i: valid_o=0 and code_o=0 next cycle -> RELEASE.
  - ready_i high before valid_o rises has no effect.
- RELEASE: stay until x_s == 0 is sampled, then -> IDLE. A held key therefore never produces a second code; it generates no auto-repeat.
- Latency: if x_in is stable one-hot from edge E0, valid_o is high after edge E0+DEB_CYCLES+2, i.e. on the (DEB_CYCLES+3)th edge. Default is 7 edges.
- Minimum re-arm: after the handshake, one edge to RELEASE, then x_s==0 (2-edge synchroniser delay after release), then one edge to IDLE.
- Code arithmetic: the index is the position of the single set bit, zero-extended to CW, plus 1. No wrap is possible given the CW check.
- busy_o is a registered decode of the state (not IDLE).

Optional Feature:
- Macro: ONEHOT_KEY_PRIORITY_EN.
- Defined: a multi-hot x_s in IDLE is not rejected. cand = the lowest set bit only, multi_o stays 0, and debounce compares x_s masked to that bit (x_s & cand != 0 counts as a match). Other bits may be present throughout.
- Undefined: behaviour as above, with multi-hot rejection and the multi_o pulse.

Test Plan:
- Reset: rst_n=0 asynchronously mid-HOLD with code 5 pending -> code_o=0, valid_o=0, busy_o=0 immediately, without waiting for a clock edge.
- Clean press: x_in=9'b000000100 held, ready_i=1 -> valid_o high after the 7th edge with code_o=4'd3; one-cycle valid; no second code while held; re-arms after x_in=0.
- Bounce: x_in toggles 9'b000010000/0 every 2 cycles for 20 cycles, then holds -> no valid during toggling; code_o=4'd5 exactly once after stable.
- Backpressure: key bit 8, ready_i=0 for 10 cycles after valid -> code_o=4'd9 stable, valid_o=1 all 10 cycles; x_in changes ignored; ready_i=1 -> valid_o=0 next cycle.
- Multi-hot: x_in=9'b000100010 -> multi_o single-cycle pulse, no valid. With ONEHOT_KEY_PRIORITY_EN: code_o=4'd2, multi_o=0.
- Top key, N=15, CW=4: x_in bit 14 -> code_o=4'd15. N=16 with CW=4 -> elaboration failure.
